dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving load/store requests from the pipeline MEM stage over a valid/ready request and response handshake.
- Byte-addressed, little-endian storage with a programmable wait-state count.
- Supports RV32I sizes and signedness, and flags misaligned, out-of-range and illegal-funct3 accesses.
- Replaces the zero-latency data memory, so MEM can stall on a real backing store.

Parameters:
- ADDR_WIDTH, 17, byte-address bits implemented; storage is 2^ADDR_WIDTH bytes.
- LATENCY, 2, wait cycles between request accept and response valid (0..15).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_we_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data; low bits used for SB/SH.
- req_funct3_i  input  3  RV32I load/store funct3.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer accepts the response.
- rsp_rdata_o  output  32  load data, sign- or zero-extended; 0 for stores and errors.
- rsp_err_o  output  1  access fault for this transaction.

Behaviour:
- Reset (async assert, sync deassert): state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, latency counter 0. Memory array is not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o, capture we/addr/wdata/funct3 and compute err.
  - Next state is WAIT with counter=LATENCY-1, or RESP directly if LATENCY=0.
- WAIT:
  - req_ready_o=0; counter decrements each cycle.
  - When counter==0, perform the access and go to RESP.
- RESP:
  - rsp_valid_o=1; rdata and err held stable until rsp_ready_i.
  - On rsp_valid_o&rsp_ready_i, go to IDLE.
- Latency: request accept edge to first rsp_valid_o cycle is LATENCY+1 cycles.
- Commit point:
  - Store bytes are written on the edge entering RESP, and only if err=0.
  - Load data is sampled on that same edge.
- funct3 decoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code sets err=1.
- Other error sources:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr[31:ADDR_WIDTH]!=0.
- On error: no array write, rsp_rdata_o=0, rsp_err_o=1, and the full latency is still observed.
- Sign extension: LB/LH replicate bit 7/15; LBU/LHU zero-fill.
- Stores: SB writes byte addr, SH bytes addr..addr+1, SW bytes addr..addr+3, little-endian.
- req_valid_i outside IDLE is ignored and not queued. The initiator holds it until accepted.
- rsp_ready_i held high in RESP completes the transaction in one cycle. Held low stalls indefinitely with outputs stable.
- Reset mid-transaction: a pending store not yet committed is discarded. An already-committed store persists. FSM returns to IDLE.

Optional Feature:
- Macro: DMEM_B2B_EN.
- Defined:
  - In RESP, req_ready_o = rsp_ready_i.
  - A new request is accepted on the same edge the response handshake completes, giving zero idle cycles between transactions.
  - Next state follows the IDLE rules for the new request.
- Undefined:
  - req_ready_o=0 in RESP.
  - At least one IDLE cycle separates consecutive transactions.

Test Plan:
- SW 0x8000_00FF to 0x100 with LATENCY=2, then LW 0x100 -> rsp_valid_o exactly 3 cycles after each accept; read returns 0x8000_00FF, rsp_err_o=0.
- Same word, LB 0x100 -> 0xFFFF_FFFF; LBU 0x100 -> 0x0000_00FF; LH 0x102 -> 0xFFFF_8000; LHU 0x102 -> 0x0000_8000.
- SH 0xABCD to 0x101 -> rsp_err_o=1, rdata 0; subsequent LW 0x100 still reads 0x8000_00FF. funct3=011 load and address 0x0002_0000 (ADDR_WIDTH=17) -> rsp_err_o=1.
- LW with rsp_ready_i low for 5 cycles in RESP -> rsp_valid_o, rdata and err stable; req_ready_o=0 throughout; a req_valid_i pulse during the stall is not accepted.
- SW 0x1234_5678 to 0x200, rst_ni asserted in WAIT -> outputs return to reset values immediately; LW 0x200 after reset returns the old value, not 0x1234_5678.
- With DMEM_B2B_EN, two back-to-back LWs with rsp_ready_i=1 -> second accept occurs on the first response edge; responses spaced LATENCY+1 cycles. Without the macro, spacing is LATENCY+2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-addressed little-endian RV32I load/store target with
// valid/ready handshakes and programmable wait states. Define DMEM_B2B_EN for back-to-back accepts.
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_funct3_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned MEM_BYTES = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W     = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? CNT_W'(0) : CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic               accept;
    logic               start;
    logic               commit;
    logic               acc_we;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [2:0]         acc_funct3;
    logic               acc_err;
    logic [ADDR_WIDTH-1:0] idx [4];
    logic [3:0][7:0]    rd_word;
    logic [31:0]        load_data;
    logic [3:0]         wr_be;
    logic               wr_en;

    logic [7:0]         mem [MEM_BYTES];

    // Illegal funct3, misalignment or an address beyond the implemented range.
    function automatic logic calc_err(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        logic bad_f3;
        logic misaligned;
        logic out_of_range;
        bad_f3       = we ? !(f3 inside {3'b000, 3'b001, 3'b010})
                          : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                       ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        out_of_range = (addr >> ADDR_WIDTH) != 32'd0;
        return bad_f3 || misaligned || out_of_range;
    endfunction

`ifdef DMEM_B2B_EN
    assign req_ready_o = req_ready_q | (rsp_valid_q & rsp_ready_i);
`else
    assign req_ready_o = req_ready_q;
`endif
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    assign accept = req_valid_i & req_ready_o;

    // With zero wait states the access uses the request as it is accepted.
    always_comb begin
        acc_we     = accept ? req_we_i     : we_q;
        acc_addr   = accept ? req_addr_i   : addr_q;
        acc_wdata  = accept ? req_wdata_i  : wdata_q;
        acc_funct3 = accept ? req_funct3_i : funct3_q;
        acc_err    = calc_err(acc_we, acc_addr, acc_funct3);
        for (int i = 0; i < 4; i++) begin
            idx[i]     = acc_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i);
            rd_word[i] = mem[idx[i]];
        end
    end

    always_comb begin
        load_data = 32'd0;
        case (acc_funct3)
            3'b000:  load_data = {{24{rd_word[0][7]}}, rd_word[0]};
            3'b001:  load_data = {{16{rd_word[1][7]}}, rd_word[1], rd_word[0]};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_word[0]};
            3'b101:  load_data = {16'd0, rd_word[1], rd_word[0]};
            default: load_data = 32'd0;
        endcase
        case (acc_funct3[1:0])
            2'b00:   wr_be = 4'b0001;
            2'b01:   wr_be = 4'b0011;
            2'b10:   wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        start       = 1'b0;
        commit      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) start = 1'b1;
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(0)) begin
                    commit  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    if (accept) start = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start) begin
            we_d     = req_we_i;
            addr_d   = req_addr_i;
            wdata_d  = req_wdata_i;
            funct3_d = req_funct3_i;
            if (LATENCY == 0) begin
                commit  = 1'b1;
                state_d = S_RESP;
            end else begin
                cnt_d   = CNT_INIT;
                state_d = S_WAIT;
            end
        end

        // Commit point: load data sampled and store bytes written on the edge entering RESP.
        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_we) ? 32'd0 : load_data;
        end

        wr_en       = commit & acc_we & ~acc_err;
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Backing store is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[idx[i]] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed transactions checked against a byte-level memory model
// every cycle, plus literal expectations for the load/store/error vectors.
module tb_dmem_responder;

    localparam int unsigned AW  = 17;
    localparam int unsigned LAT = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [2:0]  req_funct3_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_funct3_i (req_funct3_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Byte-addressed reference memory.
    logic [7:0] mmem [int unsigned];

    function automatic logic [7:0] rdbyte(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : 8'h00;
    endfunction

    task automatic model_eval(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [2:0] f3, output logic [31:0] rd, output logic err);
        int unsigned sz;
        bit sgn;
        bit legal;
        longint unsigned v;
        sz = 1; sgn = 0; legal = 1;
        case (f3)
            3'd0:    begin sz = 1; sgn = 1; end
            3'd1:    begin sz = 2; sgn = 1; end
            3'd2:    begin sz = 4; end
            3'd4:    begin sz = 1; legal = !we; end
            3'd5:    begin sz = 2; legal = !we; end
            default: legal = 0;
        endcase
        err = !legal || ((addr % sz) != 0) || (addr >= (32'd1 << AW));
        rd = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < int'(sz); i++) mmem[addr + 32'(i)] = 8'(wd >> (8 * i));
            end else begin
                v = 0;
                for (int i = 0; i < int'(sz); i++) v |= longint'(rdbyte(addr + 32'(i))) << (8 * i);
                if (sgn && v >= (64'd1 << (8 * sz - 1))) v = v + (64'hFFFF_FFFF_FFFF_FFFF << (8 * sz));
                rd = v[31:0];
            end
        end
    endtask

    // Reference state: one accepted-but-unanswered transaction and one live response.
    bit          pend_v = 0;
    int          pend_due;
    logic        pend_we;
    logic [31:0] pend_addr, pend_wd;
    logic [2:0]  pend_f3;
    bit          act_v = 0;
    logic [31:0] act_rd;
    logic        act_err;

    always @(negedge clk_i) begin : cmp
        logic exp_ready;
        if (!rst_ni) begin
            pend_v = 0;
            act_v  = 0;
            chk("rst_req_ready", 32'(req_ready_o), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
            chk("rst_rsp_err",   32'(rsp_err_o), 32'd0);
        end else begin
            if (!act_v && pend_v && cyc == pend_due) begin
                model_eval(pend_we, pend_addr, pend_wd, pend_f3, act_rd, act_err);
                act_v  = 1;
                pend_v = 0;
            end
            chk("rsp_valid", 32'(rsp_valid_o), 32'(act_v));
            if (act_v) begin
                chk("rsp_rdata", rsp_rdata_o, act_rd);
                chk("rsp_err", 32'(rsp_err_o), 32'(act_err));
            end
            exp_ready = !act_v && !pend_v;
`ifdef DMEM_B2B_EN
            if (act_v && rsp_ready_i) exp_ready = 1'b1;
`endif
            chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
            if (act_v && rsp_ready_i) act_v = 0;
            if (req_valid_i && exp_ready) begin
                pend_v    = 1;
                pend_due  = cyc + int'(LAT) + 1;
                pend_we   = req_we_i;
                pend_addr = req_addr_i;
                pend_wd   = req_wdata_i;
                pend_f3   = req_funct3_i;
            end
        end
    end

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, input int stall,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(posedge clk_i); #1;
        req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_funct3_i = f3;
        rsp_ready_i = (stall == 0);
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 50) begin @(negedge clk_i); n++; end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk_i); #1;
        req_valid_i = 0;
        lat = 0;
        do begin @(negedge clk_i); lat++; end while (!rsp_valid_o && lat < 50);
        rd = rsp_rdata_o;
        er = rsp_err_o;
        if (stall == 0) begin
            @(posedge clk_i); #1;
            rsp_ready_i = 0;
        end else begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk_i); #1;
                req_valid_i = (i == 1);
                req_we_i = 0; req_addr_i = 32'h300; req_funct3_i = 3'b010;
                @(negedge clk_i);
                chk("stall_rsp_valid", 32'(rsp_valid_o), 32'd1);
                chk("stall_req_ready", 32'(req_ready_o), 32'd0);
            end
            @(posedge clk_i); #1;
            req_valid_i = 0;
            rsp_ready_i = 1;
            @(negedge clk_i);
            @(posedge clk_i); #1;
            rsp_ready_i = 0;
        end
    endtask

    task automatic run(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3, input int stall,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic er;
        int lat;
        txn(we, addr, wd, f3, stall, rd, er, lat);
        chk({name, "_lat"}, 32'(lat), 32'(LAT + 1));
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_err"}, 32'(er), 32'(exp_err));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : drive
        int acc_cnt;
        int rsp_cnt;
        int acc_cyc [2];
        int rsp_cyc [2];
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1;

        run("sw_100",  1, 32'h0000_0100, 32'h8000_00FF, 3'b010, 0, 32'h0000_0000, 0);
        run("lw_100",  0, 32'h0000_0100, 32'h0,        3'b010, 0, 32'h8000_00FF, 0);
        run("lb_100",  0, 32'h0000_0100, 32'h0,        3'b000, 0, 32'hFFFF_FFFF, 0);
        run("lbu_100", 0, 32'h0000_0100, 32'h0,        3'b100, 0, 32'h0000_00FF, 0);
        run("lh_102",  0, 32'h0000_0102, 32'h0,        3'b001, 0, 32'hFFFF_8000, 0);
        run("lhu_102", 0, 32'h0000_0102, 32'h0,        3'b101, 0, 32'h0000_8000, 0);
        run("sh_mis",  1, 32'h0000_0101, 32'h0000_ABCD, 3'b001, 0, 32'h0000_0000, 1);
        run("lw_keep", 0, 32'h0000_0100, 32'h0,        3'b010, 0, 32'h8000_00FF, 0);
        run("ld_f011", 0, 32'h0000_0100, 32'h0,        3'b011, 0, 32'h0000_0000, 1);
        run("lw_oor",  0, 32'h0002_0000, 32'h0,        3'b010, 0, 32'h0000_0000, 1);
        run("st_f100", 1, 32'h0000_0300, 32'h1,        3'b100, 0, 32'h0000_0000, 1);
        run("lw_mis",  0, 32'h0000_0102, 32'h0,        3'b010, 0, 32'h0000_0000, 1);
        run("sb_301",  1, 32'h0000_0301, 32'hFFFF_FF7E, 3'b000, 0, 32'h0000_0000, 0);
        run("lbu_301", 0, 32'h0000_0301, 32'h0,        3'b100, 0, 32'h0000_007E, 0);
        run("lw_stall", 0, 32'h0000_0100, 32'h0,       3'b010, 5, 32'h8000_00FF, 0);
        run("sw_200",  1, 32'h0000_0200, 32'hCAFE_BABE, 3'b010, 0, 32'h0000_0000, 0);

        // Store interrupted by reset while waiting must not reach memory.
        @(posedge clk_i); #1;
        req_valid_i = 1; req_we_i = 1; req_addr_i = 32'h200; req_wdata_i = 32'h1234_5678;
        req_funct3_i = 3'b010; rsp_ready_i = 0;
        @(negedge clk_i);
        chk("irq_accept", 32'(req_ready_o), 32'd1);
        @(posedge clk_i); #1;
        req_valid_i = 0;
        @(posedge clk_i); #1;
        rst_ni = 0;
        #1;
        chk("irq_rsp_valid_now", 32'(rsp_valid_o), 32'd0);
        chk("irq_req_ready_now", 32'(req_ready_o), 32'd1);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;
        run("lw_200",  0, 32'h0000_0200, 32'h0,        3'b010, 0, 32'hCAFE_BABE, 0);

        // Two loads with the request held and the consumer always ready.
        acc_cnt = 0; rsp_cnt = 0;
        acc_cyc = '{0, 0}; rsp_cyc = '{0, 0};
        @(posedge clk_i); #1;
        req_valid_i = 1; req_we_i = 0; req_addr_i = 32'h100; req_funct3_i = 3'b010; rsp_ready_i = 1;
        for (int i = 0; i < 40 && rsp_cnt < 2; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
                if (rsp_cnt < 2) rsp_cyc[rsp_cnt] = cyc;
                rsp_cnt++;
            end
            if (req_valid_i && req_ready_o) begin
                if (acc_cnt < 2) acc_cyc[acc_cnt] = cyc;
                acc_cnt++;
            end
            @(posedge clk_i); #1;
            if (acc_cnt >= 2) req_valid_i = 0;
        end
        req_valid_i = 0;
        rsp_ready_i = 0;
        chk("b2b_rsp_count", 32'(rsp_cnt), 32'd2);
        chk("b2b_acc_count", 32'(acc_cnt), 32'd2);
        chk("b2b_first_lat", 32'(rsp_cyc[0] - acc_cyc[0]), 32'(LAT + 1));
`ifdef DMEM_B2B_EN
        chk("b2b_spacing", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'(LAT + 1));
        chk("b2b_second_accept", 32'(acc_cyc[1] - rsp_cyc[0]), 32'd0);
`else
        chk("b2b_spacing", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'(LAT + 2));
        chk("b2b_second_accept", 32'(acc_cyc[1] - rsp_cyc[0]), 32'd1);
`endif

        repeat (3) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
